// File: rtl/mux41_pkg.sv
// Shared constants and types for the 4:1 lane multiplexer.
//   LANES : number of data lanes (4)
//   SEL_W : width of the lane select (2)
//   sel_t : lane select type
package mux41_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Top value of a CW-bit counter; the counters stop here instead of wrapping.
  function automatic logic [31:0] sat_max(input int unsigned cw);
    logic [31:0] one_v;
    one_v = 32'd1;
    if (cw >= 32) begin
      sat_max = 32'hFFFF_FFFF;
    end else begin
      sat_max = (one_v << cw) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// CW-bit saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : increment request (ignored once saturated)
//   clr   : synchronous clear, wins over en
//   cnt   : current count (registered)
module sat_counter
  import mux41_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam logic [31:0] MAX_V = sat_max(CW);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: clear first, then increment unless already at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en && (cnt_q != MAX_V[CW-1:0])) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux_41_1007.sv
// 4:1 lane multiplexer with registered copy, select-change pulse and
// per-lane usage counters.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset of all registered state
//   i       : four W-bit lanes, lane k at [k*W +: W]
//   s       : lane select
//   en      : capture enable for o_q, s_q, sel_chg and the counters
//   clr     : synchronous clear of the usage counters only
//   o       : combinational selected lane
//   o_q     : registered selected lane (one cycle latency)
//   sel_chg : one-cycle pulse when a capture sees s differ from s_q
//   cnt     : four CW-bit saturating usage counters, counter k at [k*CW +: CW]
module mux_41_1007
  import mux41_pkg::*;
#(
  parameter int W  = 1,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES*W-1:0]  i,
  input  logic [SEL_W-1:0]    s,
  input  logic                en,
  input  logic                clr,
  output logic [W-1:0]        o,
  output logic [W-1:0]        o_q,
  output logic                sel_chg,
  output logic [LANES*CW-1:0] cnt
);

  logic [W-1:0] o_q_d;
  logic [W-1:0] o_q_q;
  sel_t         s_q_d;
  sel_t         s_q_q;
  logic         sel_chg_d;
  logic         sel_chg_q;
  logic [LANES-1:0] lane_en;

  // Lane select; an unknown select yields X rather than a substituted lane.
  always_comb begin
    o = {W{1'b0}};
    case (s)
      2'd0:    o = i[0*W +: W];
      2'd1:    o = i[1*W +: W];
      2'd2:    o = i[2*W +: W];
      2'd3:    o = i[3*W +: W];
      default: o = {W{1'bx}};
    endcase
  end

  // Capture path: load on en, otherwise hold; the change pulse drops without en.
  always_comb begin
    o_q_d     = o_q_q;
    s_q_d     = s_q_q;
    sel_chg_d = 1'b0;
    if (en) begin
      o_q_d     = o;
      s_q_d     = s;
      sel_chg_d = (s != s_q_q);
    end else begin
      o_q_d     = o_q_q;
      s_q_d     = s_q_q;
      sel_chg_d = 1'b0;
    end
  end

  // Captured output, select and change pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q_q     <= {W{1'b0}};
      s_q_q     <= 2'd0;
      sel_chg_q <= 1'b0;
    end else begin
      o_q_q     <= o_q_d;
      s_q_q     <= s_q_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign o_q     = o_q_q;
  assign sel_chg = sel_chg_q;

  // One usage counter per lane, bumped only when that lane is captured.
  for (genvar k = 0; k < LANES; k++) begin : g_cnt
    assign lane_en[k] = en && (s == sel_t'(k));

    sat_counter #(
      .CW (CW)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (lane_en[k]),
      .clr   (clr),
      .cnt   (cnt[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_mux_41_1007.sv
module tb_mux_41_1007;

  localparam int W  = 1;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic [4*W-1:0] i;
  logic [1:0]    s;
  logic          en;
  logic          clr;
  logic [W-1:0]  o;
  logic [W-1:0]  o_q;
  logic          sel_chg;
  logic [4*CW-1:0] cnt;

  int checks;
  int errors;

  mux_41_1007 #(.W(W), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .s       (s),
    .en      (en),
    .clr     (clr),
    .o       (o),
    .o_q     (o_q),
    .sel_chg (sel_chg),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then settle past it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] cnt_lane(input logic [4*CW-1:0] c, input int k);
    return 32'(c[k*CW +: CW]);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; s = 2'd0; i = 4'b0000;
    #3;
    chk("rst_o_q", o_q, 0);
    chk("rst_sel_chg", sel_chg, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1'b1;

    // Combinational select, lane 0
    i = 4'b0000; s = 2'd0; #1; chk("s0_a", o, 0);
    i = 4'b0010; #1; chk("s0_b", o, 0);
    i = 4'b0001; #1; chk("s0_c", o, 1);
    // Lane 1
    s = 2'd1; i = 4'b0010; #1; chk("s1_a", o, 1);
    i = 4'b1101; #1; chk("s1_b", o, 0);
    // Walking one on lanes 2 and 3
    for (int p = 0; p < 4; p++) begin
      s = 2'd2; i = 4'b0001 << p; #1; chk("walk_s2", o, (p == 2) ? 1 : 0);
      s = 2'd3; #1; chk("walk_s3", o, (p == 3) ? 1 : 0);
    end
    // en=0 edges left everything at reset values
    tick();
    chk("idle_o_q", o_q, 0);
    chk("idle_cnt", cnt, 0);

    // Hold s=2 for three captures, then s=0 for one
    en = 1'b1; s = 2'd2; i = 4'b0100;
    tick(); chk("s2_c1_chg", sel_chg, 1); chk("s2_c1_oq", o_q, 1); chk("s2_c1_cnt", cnt_lane(cnt, 2), 1);
    tick(); chk("s2_c2_chg", sel_chg, 0);
    tick(); chk("s2_c3_chg", sel_chg, 0); chk("s2_c3_cnt", cnt_lane(cnt, 2), 3);
    s = 2'd0;
    tick(); chk("s0_chg", sel_chg, 1); chk("s0_cnt2", cnt_lane(cnt, 2), 3);
    chk("s0_cnt0", cnt_lane(cnt, 0), 1); chk("s0_oq", o_q, 0);

    // en=0: o follows i, registered state holds, pulse drops
    en = 1'b0; s = 2'd2; i = 4'b0000; #1; chk("hold_o_a", o, 0);
    i = 4'b0100; #1; chk("hold_o_b", o, 1);
    tick(); chk("hold_oq", o_q, 0); chk("hold_chg", sel_chg, 0);
    chk("hold_cnt", cnt, 8'b00_11_00_01);
    i = 4'b1011; #1; chk("hold_o_c", o, 0);
    tick(); chk("hold_oq2", o_q, 0); chk("hold_cnt2", cnt, 8'b00_11_00_01);

    // Saturation on lane 3 (CW=2)
    en = 1'b1; s = 2'd3; i = 4'b1000;
    tick(); chk("sat_chg", sel_chg, 1); chk("sat_c1", cnt_lane(cnt, 3), 1);
    tick(); chk("sat_c2", cnt_lane(cnt, 3), 2); chk("sat_chg2", sel_chg, 0);
    tick(); chk("sat_c3", cnt_lane(cnt, 3), 3);
    tick(); chk("sat_c4", cnt_lane(cnt, 3), 3);
    tick(); chk("sat_c5", cnt_lane(cnt, 3), 3); chk("sat_oq", o_q, 1);

    // Clear wins over increment, leaves capture path alone
    clr = 1'b1; s = 2'd1; i = 4'b0010;
    tick(); chk("clr_cnt", cnt, 0); chk("clr_oq", o_q, 1); chk("clr_chg", sel_chg, 1);
    clr = 1'b0; s = 2'd1;
    tick(); chk("post_clr_cnt1", cnt_lane(cnt, 1), 1); chk("post_clr_chg", sel_chg, 0);

    // Async reset between edges while o_q=1
    #2; rst_n = 1'b0; #1;
    chk("arst_oq", o_q, 0); chk("arst_cnt", cnt, 0); chk("arst_chg", sel_chg, 0);
    chk("arst_o", o, 1);
    #1; rst_n = 1'b1; s = 2'd0; i = 4'b0001;
    // First capture after reset compares against s_q=0
    tick(); chk("rel_chg0", sel_chg, 0); chk("rel_oq", o_q, 1); chk("rel_cnt0", cnt_lane(cnt, 0), 1);
    s = 2'd1;
    tick(); chk("rel_chg1", sel_chg, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
